// File: rtl/uart_tx16_pkg.sv
// Shared UART definitions for the NBBPU serial path.
// The transmitter uses them now, and the future receiver is meant to reuse them.
package nbbpu_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int FRAME_BITS           = 10;
  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  function automatic logic [7:0] word_byte(input logic [15:0] word, input logic hi);
    word_byte = hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/uart_tx16_if.sv
// Word handshake between the processor store side and the UART transmitter.
interface uart_tx16_if #(
  parameter int WIDTH = 16
);
  logic             valid;
  logic [WIDTH-1:0] data_in;
  logic             ready;
  logic             busy;

  modport master (
    output valid,
    output data_in,
    input  ready,
    input  busy
  );

  modport slave (
    input  valid,
    input  data_in,
    output ready,
    output busy
  );
endinterface

// File: rtl/uart_tx16_baud_counter.sv
// Bit-period counter that runs 0..CLKS_PER_BIT-1 and flags the final cycle of each bit.
module uart_baud_counter
  import nbbpu_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Wrap on the final cycle so the next bit always starts from zero.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx16.sv
// 16-bit word to dual 8N1 frame UART transmitter, low byte first, with state updated on the falling clock edge.
module uart_tx16
  import nbbpu_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic          clock,
  input  logic          reset,
  uart_tx16_if.slave    bus,
  output logic          tx
);

  uart_state_e state, state_next;
  logic [7:0]  shift, shift_next;
  logic [15:0] held, held_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic        hi_byte, hi_byte_next;
  logic        tx_next;
  logic        tick;
  logic        baud_clear;
  logic        ready;
  logic        accept;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock(clock),
    .reset(reset),
    .clear(baud_clear),
    .tick (tick)
  );

  assign baud_clear = (state == IDLE);

  // Ready includes the final cycle of the high-byte stop bit, so a waiting word starts with no idle gap.
  assign ready  = (state == IDLE) || ((state == STOP) && hi_byte && tick);
  assign accept = bus.valid && ready;

  assign bus.ready = ready;
  assign bus.busy  = ~ready;

  // Next-state and datapath decode; tx is computed from the next state so the pin stays registered.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    held_next    = held;
    bit_idx_next = bit_idx;
    hi_byte_next = hi_byte;
    tx_next      = 1'b1;
    case (state)
      IDLE: begin
        if (accept) begin
          held_next    = bus.data_in;
          shift_next   = word_byte(bus.data_in, 1'b0);
          hi_byte_next = 1'b0;
          bit_idx_next = 3'd0;
          state_next   = START;
        end else begin
          state_next   = IDLE;
        end
      end
      START: begin
        if (tick) begin
          bit_idx_next = 3'd0;
          state_next   = DATA;
        end else begin
          state_next   = START;
        end
      end
      DATA: begin
        if (tick) begin
          shift_next = {1'b0, shift[7:1]};
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            state_next   = DATA;
          end
        end else begin
          state_next = DATA;
        end
      end
      STOP: begin
        if (tick) begin
          if (!hi_byte) begin
            shift_next   = word_byte(held, 1'b1);
            hi_byte_next = 1'b1;
            state_next   = START;
          end else if (accept) begin
            held_next    = bus.data_in;
            shift_next   = word_byte(bus.data_in, 1'b0);
            hi_byte_next = 1'b0;
            bit_idx_next = 3'd0;
            state_next   = START;
          end else begin
            state_next   = IDLE;
          end
        end else begin
          state_next = STOP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  // State, datapath and line registers.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= 8'h00;
      held    <= 16'h0000;
      bit_idx <= 3'd0;
      hi_byte <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      shift   <= shift_next;
      held    <= held_next;
      bit_idx <= bit_idx_next;
      hi_byte <= hi_byte_next;
      tx      <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx16.sv
// Scoreboard bench for uart_tx16 at CLKS_PER_BIT=16 and CLKS_PER_BIT=2.
module tb_uart_tx16;

  localparam int NB0 = 16;
  localparam int NB1 = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  uart_tx16_if #(.WIDTH(16)) bus0 ();
  uart_tx16_if #(.WIDTH(16)) bus1 ();
  logic tx0, tx1;

  uart_tx16 #(.CLKS_PER_BIT(NB0)) dut0 (.clock(clock), .reset(reset), .bus(bus0), .tx(tx0));
  uart_tx16 #(.CLKS_PER_BIT(NB1)) dut1 (.clock(clock), .reset(reset), .bus(bus1), .tx(tx1));

  logic        valid_a [2];
  logic [15:0] data_a  [2];
  assign bus0.valid   = valid_a[0];
  assign bus0.data_in = data_a[0];
  assign bus1.valid   = valid_a[1];
  assign bus1.data_in = data_a[1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int free_at [2];
  int acc_cnt [2];
  int          exp_start_q [2][$];
  logic [7:0]  exp_byte_q  [2][$];

  function automatic int nb(input int i);
    return (i == 0) ? NB0 : NB1;
  endfunction

  function automatic logic tx_of(input int i);
    return (i == 0) ? tx0 : tx1;
  endfunction

  function automatic logic ready_of(input int i);
    return (i == 0) ? bus0.ready : bus1.ready;
  endfunction

  function automatic logic busy_of(input int i);
    return (i == 0) ? bus0.busy : bus1.busy;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a word is taken at an edge when valid is high and the previous word's 20 bits are over.
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (valid_a[i] && (free_at[i] <= cyc)) begin
          exp_start_q[i].push_back(cyc);
          exp_byte_q[i].push_back(data_a[i][7:0]);
          exp_start_q[i].push_back(cyc + 10 * nb(i));
          exp_byte_q[i].push_back(data_a[i][15:8]);
          free_at[i] = cyc + 20 * nb(i);
          acc_cnt[i] = acc_cnt[i] + 1;
        end
      end
    end
  end

  // Handshake and idle-line expectations, sampled mid-cycle.
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("ready%0d", i), 32'(ready_of(i)), 32'(free_at[i] <= cyc + 1));
        check($sformatf("busy%0d", i), 32'(busy_of(i)), 32'(free_at[i] > cyc + 1));
        if (free_at[i] <= cyc) check($sformatf("idle_tx%0d", i), 32'(tx_of(i)), 32'd1);
      end
    end
  end

  task automatic monitor(input int idx);
    int n, start, exp_start;
    logic bitv, shape_ok, aborted;
    logic [7:0] byte_v, exp_byte;
    n = nb(idx);
    forever begin
      @(posedge clock);
      if (!reset && (tx_of(idx) == 1'b0)) begin
        start = cyc; aborted = 1'b0; shape_ok = 1'b1; byte_v = 8'h00; bitv = 1'b0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int k = 0; k < n && !aborted; k++) begin
            if (b != 0 || k != 0) @(posedge clock);
            if (reset) aborted = 1'b1;
            else if (k == 0) bitv = tx_of(idx);
            else if (tx_of(idx) !== bitv) shape_ok = 1'b0;
          end
          if (!aborted) begin
            if (b == 9 && bitv !== 1'b1) shape_ok = 1'b0;
            else if (b >= 1 && b <= 8) byte_v[b-1] = bitv;
          end
        end
        if (!aborted) begin
          if (exp_start_q[idx].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected%0d: got byte %0h at cycle %0d, expected no frame", idx, byte_v, start);
          end else begin
            exp_start = exp_start_q[idx].pop_front();
            exp_byte  = exp_byte_q[idx].pop_front();
            check($sformatf("frame_start%0d", idx), 32'(start), 32'(exp_start));
            check($sformatf("frame_byte%0d", idx), 32'(byte_v), 32'(exp_byte));
            check($sformatf("frame_shape%0d", idx), 32'(shape_ok), 32'd1);
          end
        end
      end
    end
  endtask

  task automatic send(input int idx, input logic [15:0] w, input bit keep);
    int target;
    @(posedge clock); #1;
    valid_a[idx] = 1'b1;
    data_a[idx]  = w;
    target = acc_cnt[idx] + 1;
    for (int t = 0; t < 40 * nb(idx) + 10 && acc_cnt[idx] < target; t++) @(posedge clock);
    check($sformatf("accept_timeout%0d", idx), 32'(acc_cnt[idx] >= target), 32'd1);
    #1;
    if (!keep) valid_a[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx);
    for (int t = 0; t < 30 * nb(idx) + 20 && !(free_at[idx] <= cyc && exp_start_q[idx].size() == 0); t++)
      @(posedge clock);
    check($sformatf("drain_timeout%0d", idx), 32'(free_at[idx] <= cyc && exp_start_q[idx].size() == 0), 32'd1);
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
    join_none
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int target, e;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      valid_a[i] = 1'b0; data_a[i] = 16'h0000; free_at[i] = 0; acc_cnt[i] = 0;
    end
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    repeat (100) @(posedge clock);

    // Single word, then back-to-back, then a word with a stray valid while busy.
    send(0, 16'hA55A, 1'b0);
    wait_done(0);
    send(0, 16'h0001, 1'b1);
    send(0, 16'h8000, 1'b0);
    wait_done(0);
    send(0, 16'h1234, 1'b0);
    repeat (50) @(posedge clock);
    #1 valid_a[0] = 1'b1; data_a[0] = 16'hFFFF;
    @(posedge clock); #1 valid_a[0] = 1'b0;
    wait_done(0);

    // valid held high while data_in changes every cycle: three words.
    target = acc_cnt[0] + 3;
    @(posedge clock); #1 valid_a[0] = 1'b1;
    for (int t = 0; t < 100 * NB0 && acc_cnt[0] < target; t++) begin
      data_a[0] = 16'($urandom);
      @(posedge clock); #1;
    end
    valid_a[0] = 1'b0;
    check("hold_accepts", 32'(acc_cnt[0]), 32'(target));
    wait_done(0);

    // Asynchronous reset in the middle of data bit 3 of the low byte.
    send(0, 16'($urandom), 1'b0);
    e = free_at[0] - 20 * NB0;
    for (int t = 0; t < 1000 && cyc < e + 4 * NB0 + NB0 / 2; t++) @(posedge clock);
    check("reset_point", 32'(cyc), 32'(e + 4 * NB0 + NB0 / 2));
    #2 reset = 1'b1;
    #1;
    check("rst_tx", 32'(tx0), 32'd1);
    check("rst_ready", 32'(bus0.ready), 32'd1);
    check("rst_busy", 32'(bus0.busy), 32'd0);
    for (int i = 0; i < 2; i++) begin
      exp_start_q[i].delete(); exp_byte_q[i].delete(); free_at[i] = 0;
    end
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    send(0, 16'h00FF, 1'b0);
    wait_done(0);

    // Random words with random gaps and random busy-time valid pulses.
    for (int k = 0; k < 3; k++) begin
      send(0, 16'($urandom), 1'b0);
      repeat ($urandom_range(20, 200)) @(posedge clock);
      #1 valid_a[0] = 1'b1; data_a[0] = 16'($urandom);
      @(posedge clock); #1 valid_a[0] = 1'b0;
      wait_done(0);
    end

    // Minimum divider.
    send(1, 16'hC3C3, 1'b0);
    wait_done(1);
    for (int k = 0; k < 20; k++) begin
      send(1, 16'($urandom), (k != 19) && ($urandom_range(0, 1) == 1));
      if (valid_a[1] == 1'b0) repeat ($urandom_range(0, 5)) @(posedge clock);
    end
    wait_done(1);

    repeat (10) @(posedge clock);
    check("leftover0", 32'(exp_start_q[0].size()), 32'd0);
    check("leftover1", 32'(exp_start_q[1].size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
